// File: rtl/enc8to3_stream_pkg.sv
// -----------------------------------------------------------------------------
// enc8to3_stream_pkg
//   Shared definitions for the sequential 8-to-3 encoder: vector/index widths,
//   the scan FSM state type and a small population helper used by the
//   priority encoder.
// -----------------------------------------------------------------------------
package enc8to3_stream_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // True when exactly one bit of v is set: clearing the lowest set bit
  // must leave nothing behind.
  function automatic logic is_single(input logic [ENC_IN_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/enc8to3_stream_prio_enc8.sv
// -----------------------------------------------------------------------------
// enc8to3_stream_prio_enc8
//   Combinational priority encoder over an 8-bit pending mask.
//   Ports:
//     pending_i [7:0]  bits still to be emitted
//     idx_o     [2:0]  index of the highest-priority set bit (0 when none)
//     onehot_o  [7:0]  one-hot mask of that bit (the bit to clear)
//     single_o         exactly one bit of pending_i is set
//     any_o            pending_i is non-zero
//   MSB_FIRST=1 gives priority to the highest index, 0 to the lowest.
// -----------------------------------------------------------------------------
module enc8to3_stream_prio_enc8
  import enc8to3_stream_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [ENC_IN_W-1:0]  pending_i,
  output logic [ENC_IDX_W-1:0] idx_o,
  output logic [ENC_IN_W-1:0]  onehot_o,
  output logic                 single_o,
  output logic                 any_o
);

  // The loop runs toward the winning end so the last match assigned wins.
  always_comb begin
    idx_o = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (pending_i[i]) idx_o = i[ENC_IDX_W-1:0];
      end
    end else begin
      for (int i = ENC_IN_W - 1; i >= 0; i--) begin
        if (pending_i[i]) idx_o = i[ENC_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    onehot_o = '0;
    if (any_o) onehot_o = {{(ENC_IN_W-1){1'b0}}, 1'b1} << idx_o;
  end

  assign any_o    = |pending_i;
  assign single_o = is_single(pending_i);

endmodule

// File: rtl/enc8to3_stream.sv
// -----------------------------------------------------------------------------
// enc8to3_stream
//   Sequential 8-to-3 encoder. Accepts a multi-hot vector over valid/ready
//   and emits the 3-bit index of each set bit, one per output transfer, in
//   priority order. out_last flags the final index of a vector; none pulses
//   for one cycle when an all-zero vector is accepted.
//   Ports:
//     clk, rst_n           clock / asynchronous active-low reset
//     en                   gates acceptance of new vectors only
//     in_valid, in_ready   input handshake (in_ready = idle && en)
//     in [7:0]             multi-hot input vector
//     out_valid, out_ready output handshake (out_valid registered)
//     out [2:0]            current index, holds its value while idle
//     out_last             current index is the last of the vector
//     none                 one-cycle pulse on an accepted all-zero vector
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no vector in flight; in_ready follows en
//   ST_SCAN | presenting indices; out_valid=1 until the out_last transfer
//
//   pending_q holds the bits that remain *after* the index currently shown on
//   out, so the single encoder instance can compute the next index directly
//   from it (in ST_SCAN) or from the incoming vector (in ST_IDLE).
// -----------------------------------------------------------------------------
module enc8to3_stream
  import enc8to3_stream_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENC_IN_W-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ENC_IDX_W-1:0] out,
  output logic                 out_last,
  output logic                 none
);

  state_e                 state_q, state_d;
  logic [ENC_IN_W-1:0]    pending_q, pending_d;
  logic [ENC_IDX_W-1:0]   out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   none_q, none_d;

  logic                   accept;
  logic                   xfer;
  logic [ENC_IN_W-1:0]    enc_src;
  logic [ENC_IDX_W-1:0]   enc_idx;
  logic [ENC_IN_W-1:0]    enc_onehot;
  logic                   enc_single;
  logic                   enc_any;

  assign in_ready = (state_q == ST_IDLE) && en;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  // While scanning, the incoming vector is ignored entirely.
  assign enc_src = (state_q == ST_IDLE) ? in : pending_q;

  enc8to3_stream_prio_enc8 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .pending_i (enc_src),
    .idx_o     (enc_idx),
    .onehot_o  (enc_onehot),
    .single_o  (enc_single),
    .any_o     (enc_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && enc_any)   state_d = ST_SCAN;
      ST_SCAN: if (xfer && out_last_q)  state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pending_d   = pending_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    none_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (enc_any) begin
            pending_d   = in & ~enc_onehot;
            out_d       = enc_idx;
            out_valid_d = 1'b1;
            out_last_d  = enc_single;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (xfer) begin
          if (out_last_q) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            pending_d  = pending_q & ~enc_onehot;
            out_d      = enc_idx;
            out_last_d = enc_single;
          end
        end
      end
      default: begin
        pending_d   = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      none_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      none_q      <= none_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_last  = out_last_q;
  assign none      = none_q;

endmodule
